fifo_sync_lookahead: RTL and testbench

Parametrised synchronous first-word-fall-through FIFO with a one-word lookahead output. It is the storage element behind the `FIFO_SIMPLE` `written`/`read_with_next` modport pair and drives `data`, `data_next`, `full`, `empty`, `almost_full` and `almost_empty` from real occupancy. It adds what the plain FIFO lacks: configurable depth and thresholds, an occupancy count, and sticky overflow/underflow error flags. It sits between the readout/decoder producers and the packetiser/transmit consumers.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_lookahead_ctrl.sv | 109 ++++++++++
 rtl/fifo_sync_lookahead.sv | 74 +++++++
 tb/tb_fifo_sync_lookahead.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the lookahead FIFO: count width, parameter legality and
// the decoded per-cycle operation.
package fifo_pkg;

  function automatic int fifo_cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit fifo_params_ok(int width, int depth, int afull, int aempty);
    return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

  // Encoding is {accepted write, accepted pop}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_lookahead_ctrl.sv
// Pointer, occupancy, flag and sticky-error control for fifo_sync_lookahead.
module fifo_lookahead_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = fifo_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_in_i,
  input  logic          shift_out_i,
  input  logic          clear_errors_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          almost_full_o,
  output logic          empty_o,
  output logic          almost_empty_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;
  fifo_op_e      op;

  always_comb begin
    wr_acc   = shift_in_i & ~full_q;
    rd_acc   = shift_out_i & ~empty_q;
    op       = fifo_op_e'({wr_acc, rd_acc});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (op)
      OP_IDLE: ;
      OP_PUSH: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + CW'(1);
      end
      OP_POP: begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q - CW'(1);
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
    endcase

    // Flags come from count_d so they settle on the same edge as count.
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AFULL_THRESH));
    aempty_d = (count_d <= CW'(AEMPTY_THRESH));

    // A new error on the clearing edge wins over the clear.
    ovf_d = (shift_in_i & full_q) | (ovf_q & ~clear_errors_i);
    udf_d = (shift_out_i & empty_q) | (udf_q & ~clear_errors_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign wr_en_o        = wr_acc;
  assign wr_ptr_o       = wr_ptr_q;
  assign rd_ptr_o       = rd_ptr_q;
  assign count_o        = count_q;
  assign full_o         = full_q;
  assign almost_full_o  = afull_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = aempty_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: rtl/fifo_sync_lookahead.sv
// Synchronous FWFT FIFO exposing the head word and the word behind it.
module fifo_sync_lookahead
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = fifo_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             almost_full,
  input  logic             shift_out,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_next,
  output logic             empty,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_errors
);

  if (!fifo_params_ok(WIDTH, DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_check
    $fatal(1, "fifo_sync_lookahead: illegal WIDTH/DEPTH/threshold parameters");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;

  fifo_lookahead_ctrl #(
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFULL_THRESH),
    .AEMPTY_THRESH (AEMPTY_THRESH)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .shift_in_i     (shift_in),
    .shift_out_i    (shift_out),
    .clear_errors_i (clear_errors),
    .wr_en_o        (wr_en),
    .wr_ptr_o       (wr_ptr),
    .rd_ptr_o       (rd_ptr),
    .count_o        (count),
    .full_o         (full),
    .almost_full_o  (almost_full),
    .empty_o        (empty),
    .almost_empty_o (almost_empty),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Outputs depend only on registered pointers/count, never on the strobes.
  always_comb begin
    rd_ptr_nxt = rd_ptr + AW'(1);
    data       = empty ? '0 : mem[rd_ptr];
    data_next  = (count >= CW'(2)) ? mem[rd_ptr_nxt] : '0;
  end

endmodule

// File: tb/tb_fifo_sync_lookahead.sv
// Scoreboard bench for fifo_sync_lookahead against a queue-based reference model.
module tb_fifo_sync_lookahead;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          shift_in = 1'b0;
  logic          shift_out = 1'b0;
  logic          clear_errors = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          full, almost_full, empty, almost_empty, overflow, underflow;
  logic [W-1:0]  data, data_next;
  logic [CW-1:0] count;

  fifo_sync_lookahead #(
    .WIDTH         (W),
    .DEPTH         (D),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .shift_in     (shift_in),
    .data_in      (data_in),
    .full         (full),
    .almost_full  (almost_full),
    .shift_out    (shift_out),
    .data         (data),
    .data_next    (data_next),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clear_errors (clear_errors)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mq[$];     // reference contents, head at index 0
  logic [W-1:0] exp_q[$];  // words the DUT must deliver on pop, in order
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = mq.size();
    cmp("count", 32'(count), n);
    cmp("empty", 32'(empty), 32'(n == 0));
    cmp("full", 32'(full), 32'(n == D));
    cmp("almost_full", 32'(almost_full), 32'(n >= AF));
    cmp("almost_empty", 32'(almost_empty), 32'(n <= AE));
    cmp("overflow", 32'(overflow), 32'(m_ovf));
    cmp("underflow", 32'(underflow), 32'(m_udf));
    cmp("data", 32'(data), (n > 0) ? 32'(mq[0]) : 32'd0);
    cmp("data_next", 32'(data_next), (n > 1) ? 32'(mq[1]) : 32'd0);
  endtask

  // Called at posedge+1; drives one cycle, advances the model, checks after the edge.
  task automatic step(input bit si, input logic [W-1:0] d, input bit so, input bit ce);
    bit wacc, racc;
    int n;
    n            = mq.size();
    shift_in     = si;
    data_in      = d;
    shift_out    = so;
    clear_errors = ce;
    wacc  = si && (n < D);
    racc  = so && (n > 0);
    m_ovf = (si && (n == D)) || (m_ovf && !ce);
    m_udf = (so && (n == 0)) || (m_udf && !ce);
    if (racc) exp_q.push_back(mq.pop_front());
    if (wacc) mq.push_back(d);
    @(posedge clk);
    #1;
    shift_in     = 1'b0;
    shift_out    = 1'b0;
    clear_errors = 1'b0;
    check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * D && mq.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_state();
    @(posedge clk);
    #1 rst = 1'b0;
    check_state();
  endtask

  // Monitor: a pop will happen on the next edge, so the head word is the one delivered.
  always @(negedge clk) begin
    if (!rst && shift_out && !empty) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_data: DUT popped 0x%0h, expected no pop", data);
      end else begin
        cmp("pop_data", 32'(data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int pw, pr;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_state();
    cmp("reset_data", 32'(data), 32'd0);

    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    cmp("three_count", 32'(count), 32'd3);
    cmp("three_data", 32'(data), 32'h11);
    cmp("three_data_next", 32'(data_next), 32'h22);
    cmp("three_aempty", 32'(almost_empty), 32'd0);
    drain();

    for (int i = 0; i < D; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    cmp("fill_full", 32'(full), 32'd1);
    cmp("fill_overflow", 32'(overflow), 32'd1);
    cmp("fill_count", 32'(count), 32'd16);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    cmp("fullrw_count", 32'(count), 32'd15);
    cmp("fullrw_data", 32'(data), 32'd1);
    cmp("fullrw_overflow", 32'(overflow), 32'd1);
    drain();

    step(1'b1, 8'h5C, 1'b1, 1'b1);
    cmp("udf_set_wins", 32'(underflow), 32'd1);
    cmp("udf_ovf_cleared", 32'(overflow), 32'd0);
    cmp("udf_count", 32'(count), 32'd1);
    cmp("udf_data", 32'(data), 32'h5C);
    cmp("udf_data_next", 32'(data_next), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      cmp("stream_count", 32'(count), 32'd5);
    end
    drain();

    for (int blk = 0; blk < 6; blk++) begin
      pw = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 50 : 20);
      pr = 100 - pw;
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
             $urandom_range(0, 31) == 0);
    end
    drain();

    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    async_reset();
    cmp("rst_count", 32'(count), 32'd0);
    cmp("rst_empty", 32'(empty), 32'd1);
    cmp("rst_data", 32'(data), 32'd0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    cmp("post_rst_data", 32'(data), 32'h3C);
    drain();

    step(1'b0, '0, 1'b0, 1'b0);
    cmp("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
